// File: rtl/qpsk_nibble_unpack.sv
// QPSK nibble unpacker: one packed 32-bit word in, four sc16 samples out.
// Each lane byte carries a 4-bit I and 4-bit Q code expanded to 16 bits.
module qpsk_nibble_unpack #(
    parameter logic ROUND_MID = 1'b0,
    parameter logic LAST_MODE = 1'b0
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] i_tdata,
    input  logic        i_tlast,
    input  logic        i_tvalid,
    output logic        i_tready,
    output logic [31:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready
);

    localparam logic       S_EMPTY = 1'b0;
    localparam logic       S_EMIT  = 1'b1;
    localparam logic [8:0] FILL    = ROUND_MID ? 9'h100 : 9'h000;

    logic        r_state;
    logic [1:0]  r_cnt;
    logic [31:0] r_word;
    logic        r_last;
    logic [31:0] r_odata;
    logic        r_olast;

    logic        w_ready;
    logic        w_accept;
    logic        w_adv;
    logic [1:0]  w_cnt_nxt;
    logic        w_olast_nxt;

    function automatic logic [15:0] f_exp(input logic [3:0] n);
        f_exp = {{4{n[3]}}, n[2:0], FILL};
    endfunction

    function automatic logic [31:0] f_samp(input logic [7:0] b);
        f_samp = {f_exp(b[7:4]), f_exp(b[3:0])};
    endfunction

    // Lane order mirrors the packer: [23:16], [31:24], [7:0], [15:8]
    function automatic logic [7:0] f_lane(
        input logic [31:0] w,
        input logic [1:0]  c
    );
        case (c)
            2'd0:    f_lane = w[23:16];
            2'd1:    f_lane = w[31:24];
            2'd2:    f_lane = w[7:0];
            default: f_lane = w[15:8];
        endcase
    endfunction

    assign w_ready     = (r_state == S_EMPTY) | ((r_cnt == 2'd3) & o_tready);
    assign w_accept    = i_tvalid & w_ready;
    assign w_adv       = (r_state == S_EMIT) & o_tready;
    assign w_cnt_nxt   = r_cnt + 2'd1;
    assign w_olast_nxt = (w_cnt_nxt == 2'd3) & (LAST_MODE | r_last);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= S_EMPTY;
            r_cnt   <= 2'd0;
            r_word  <= 32'd0;
            r_last  <= 1'b0;
            r_odata <= 32'd0;
            r_olast <= 1'b0;
        end else if (w_accept) begin
            r_state <= S_EMIT;
            r_cnt   <= 2'd0;
            r_word  <= i_tdata;
            r_last  <= i_tlast;
            r_odata <= f_samp(i_tdata[23:16]);
            r_olast <= 1'b0;
        end else if (w_adv) begin
            if (r_cnt == 2'd3) begin
                r_state <= S_EMPTY;
                r_cnt   <= 2'd0;
                r_olast <= 1'b0;
            end else begin
                r_cnt   <= w_cnt_nxt;
                r_odata <= f_samp(f_lane(r_word, w_cnt_nxt));
                r_olast <= w_olast_nxt;
            end
        end
    end

    assign i_tready = w_ready;
    assign o_tdata  = r_odata;
    assign o_tlast  = r_olast;
    assign o_tvalid = r_state;

endmodule

// File: tb/tb_qpsk_nibble_unpack.sv
// Directed and randomized check of qpsk_nibble_unpack in two parameter sets:
// dut0 (ROUND_MID=0, LAST_MODE=0) and dut1 (ROUND_MID=1, LAST_MODE=1).
module tb_qpsk_nibble_unpack;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] i_tdata;
    logic        i_tlast;
    logic        i_tvalid;
    logic        o_tready;

    logic [31:0] o_tdata0, o_tdata1;
    logic        o_tlast0, o_tlast1;
    logic        o_tvalid0, o_tvalid1;
    logic        i_tready0, i_tready1;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    qpsk_nibble_unpack #(.ROUND_MID(1'b0), .LAST_MODE(1'b0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready0),
        .o_tdata(o_tdata0), .o_tlast(o_tlast0),
        .o_tvalid(o_tvalid0), .o_tready(o_tready)
    );

    qpsk_nibble_unpack #(.ROUND_MID(1'b1), .LAST_MODE(1'b1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready1),
        .o_tdata(o_tdata1), .o_tlast(o_tlast1),
        .o_tvalid(o_tvalid1), .o_tready(o_tready)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference expansion of one 4-bit code to 16 bits
    function automatic logic [15:0] m_exp(input logic [3:0] n, input logic rm);
        logic [15:0] v;
        v = n[3] ? 16'hF000 : 16'h0000;
        v = v | (16'(n[2:0]) << 9);
        if (rm) v = v | 16'h0100;
        return v;
    endfunction

    function automatic logic [31:0] m_samp(input logic [7:0] b, input logic rm);
        return {m_exp(b[7:4], rm), m_exp(b[3:0], rm)};
    endfunction

    logic [31:0] e0 [4];
    logic [31:0] e1 [4];
    logic [65:0] q [$];
    logic [65:0] ex;
    logic [7:0]  lanes [4];
    logic [31:0] held;
    logic        stall_prev, acc_prev, fire, acc;
    int          sent;
    localparam int NW = 1000;

    initial begin
        reset_n  = 1'b0;
        i_tdata  = 32'd0;
        i_tlast  = 1'b0;
        i_tvalid = 1'b0;
        o_tready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid0", o_tvalid0, 1'b0);
        chk("rst_valid1", o_tvalid1, 1'b0);
        chk("rst_data0", o_tdata0, 32'h0);
        chk("rst_last1", o_tlast1, 1'b0);
        chk("rst_ready0", i_tready0, 1'b1);

        // Tests 1/2: word 0x12345678, both fill modes
        e0 = '{32'h06000800, 32'h02000400, 32'h0E00F000, 32'h0A000C00};
        e1 = '{32'h07000900, 32'h03000500, 32'h0F00F100, 32'h0B000D00};
        reset_n  = 1'b1;
        i_tdata  = 32'h12345678;
        i_tvalid = 1'b1;
        #1 chk("t1_ready", i_tready0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_tvalid = 1'b0;
            #1;
            chk($sformatf("t1_valid%0d", k), o_tvalid0, 1'b1);
            chk($sformatf("t1_data%0d", k), o_tdata0, e0[k]);
            chk($sformatf("t2_data%0d", k), o_tdata1, e1[k]);
            chk($sformatf("t1_last0_%0d", k), o_tlast0, 1'b0);
            chk($sformatf("t1_last1_%0d", k), o_tlast1, 1'(k == 3));
        end
        @(negedge clk);
        #1 chk("t1_idle", o_tvalid0, 1'b0);

        // Test 3: 0xFFFFFFFF then two back-to-back zero words
        i_tdata  = 32'hFFFFFFFF;
        i_tvalid = 1'b1;
        @(negedge clk);
        i_tdata = 32'h0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("t3_ff%0d", k), o_tdata0, 32'hFE00FE00);
            chk($sformatf("t3_ffr%0d", k), o_tdata1, 32'hFF00FF00);
            chk($sformatf("t3_rdy_ff%0d", k), i_tready0, 1'(k == 3));
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            #1;
            chk($sformatf("t3_v%0d", k), o_tvalid0, 1'b1);
            chk($sformatf("t3_z%0d", k), o_tdata0, 32'h0);
            chk($sformatf("t3_zr%0d", k), o_tdata1, 32'h01000100);
            chk($sformatf("t3_rdy%0d", k), i_tready0, 1'(k % 4 == 3));
            if (k == 7) i_tvalid = 1'b0;
        end
        @(negedge clk);
        #1 chk("t3_idle", o_tvalid1, 1'b0);

        // Test 4: two words, second one carries i_tlast
        i_tdata  = 32'h11111111;
        i_tlast  = 1'b0;
        i_tvalid = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (k == 0) begin
                i_tdata = 32'h99999999;
                i_tlast = 1'b1;
            end
            #1;
            chk($sformatf("t4_d%0d", k), o_tdata0,
                (k < 4) ? 32'h02000200 : 32'hF200F200);
            chk($sformatf("t4_l0_%0d", k), o_tlast0, 1'(k == 7));
            chk($sformatf("t4_l1_%0d", k), o_tlast1, 1'(k == 3 || k == 7));
            if (k == 7) begin
                i_tvalid = 1'b0;
                i_tlast  = 1'b0;
            end
        end
        @(negedge clk);
        #1 chk("t4_idle", o_tvalid0, 1'b0);

        // Test 5: random words against the reference model, random backpressure
        sent       = 0;
        stall_prev = 1'b0;
        acc_prev   = 1'b0;
        held       = 32'h0;
        for (int cyc = 0; cyc < 30000 && !(sent == NW && q.size() == 0); cyc++) begin
            @(negedge clk);
            if (stall_prev) chk("t5_hold", o_tdata0, held);
            if (acc_prev) i_tvalid = 1'b0;
            o_tready = 1'($urandom_range(0, 1));
            if (!i_tvalid && sent < NW && $urandom_range(0, 3) != 0) begin
                i_tdata  = $urandom;
                i_tlast  = 1'($urandom_range(0, 1));
                i_tvalid = 1'b1;
            end
            #1;
            fire = o_tvalid0 & o_tready;
            acc  = i_tvalid & i_tready0;
            chk("t5_rdy_match", i_tready1, i_tready0);
            if (fire) begin
                chk("t5_qnonempty", 1'(q.size() != 0), 1'b1);
                if (q.size() != 0) begin
                    ex = q.pop_front();
                    chk("t5_data0", o_tdata0, ex[31:0]);
                    chk("t5_data1", o_tdata1, ex[63:32]);
                    chk("t5_last0", o_tlast0, ex[64]);
                    chk("t5_last1", o_tlast1, ex[65]);
                end
            end
            if (acc) begin
                lanes = '{i_tdata[23:16], i_tdata[31:24], i_tdata[7:0], i_tdata[15:8]};
                for (int k = 0; k < 4; k++)
                    q.push_back({1'(k == 3), 1'(k == 3 && i_tlast),
                                 m_samp(lanes[k], 1'b1), m_samp(lanes[k], 1'b0)});
                sent++;
            end
            acc_prev   = acc;
            stall_prev = o_tvalid0 & ~o_tready;
            held       = o_tdata0;
        end
        chk("t5_done", 1'(sent == NW && q.size() == 0), 1'b1);
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
        o_tready = 1'b1;
        repeat (6) @(negedge clk);

        // Test 6: reset after the second sample of a word
        i_tdata  = 32'h12345678;
        i_tvalid = 1'b1;
        @(negedge clk);
        i_tvalid = 1'b0;
        #1 chk("t6_s0", o_tdata0, e0[0]);
        @(negedge clk);
        #1 chk("t6_s1", o_tdata0, e0[1]);
        reset_n = 1'b0;
        @(negedge clk);
        #1;
        chk("t6_rst_valid", o_tvalid0, 1'b0);
        chk("t6_rst_data", o_tdata0, 32'h0);
        chk("t6_rst_ready", i_tready0, 1'b1);
        reset_n = 1'b1;
        @(negedge clk);
        #1 chk("t6_no_partial", o_tvalid0, 1'b0);
        i_tvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            i_tvalid = 1'b0;
            #1;
            chk($sformatf("t6_v%0d", k), o_tvalid0, 1'b1);
            chk($sformatf("t6_d%0d", k), o_tdata0, e0[k]);
        end
        @(negedge clk);
        #1 chk("t6_idle", o_tvalid0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
